// File: rtl/axi_mem_slave.sv
// axi_mem_slave
//   AXI3 responder backed by a 2^MEM_AW x 32-bit on-chip word array starting at
//   byte address 0. It has an independent write engine (AW/W/B) and an
//   independent read engine (AR/R). Each engine holds at most one burst in flight.
//   Only 4-byte beats with FIXED or INCR bursts are served. Any other burst is
//   answered with SLVERR, and so is a burst that touches a word outside the array.
//   An errored write never modifies the array. An errored read returns zero data.
// Ports
//   clk, rst                          clock (rising edge), async active-high reset
//   aw*_i / awready_o                 write address channel
//   wid_i, wdata_i, wstrb_i, wlast_i,
//   wvalid_i / wready_o               write data channel (wid_i is not checked)
//   bid_o, bresp_o, bvalid_o / bready_i   write response channel
//   ar*_i / arready_o                 read address channel
//   rid_o, rdata_o, rresp_o, rlast_o,
//   rvalid_o / rready_i               read data channel
module axi_mem_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   awid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [3:0]            awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ID_WIDTH-1:0]   wid_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [ID_WIDTH-1:0]   bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [3:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [ID_WIDTH-1:0]   rid_o,
  output logic [31:0]           rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  // A burst is in error when it is not 4 B/beat, not FIXED/INCR, is unaligned,
  // or when its highest word lies beyond the array. For FIXED bursts the highest
  // word is the start word. The sum is one bit wider than the word address, so
  // it cannot wrap.
  function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [3:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
    logic [ADDR_WIDTH-2:0] last_word;
    last_word = {1'b0, addr[ADDR_WIDTH-1:2]} +
                ((burst == 2'd1) ? {{(ADDR_WIDTH-5){1'b0}}, len} : {(ADDR_WIDTH-1){1'b0}});
    burst_err = (size != 3'd2) || (burst[1] == 1'b1) || (addr[1:0] != 2'b00) ||
                (last_word[ADDR_WIDTH-2:MEM_AW] != '0);
  endfunction

  logic [31:0] mem_r [2**MEM_AW];

  w_state_e              w_state_r, w_state_nx_s;
  logic [ID_WIDTH-1:0]   wid_r;
  logic [MEM_AW-1:0]     waddr_r;
  logic [3:0]            wlen_r, wbeat_r;
  logic                  wincr_r, werr_r;
  logic                  aw_fire_s, w_fire_s, w_last_s, mem_we_s;

  r_state_e              r_state_r, r_state_nx_s;
  logic [ID_WIDTH-1:0]   rid_r;
  logic [MEM_AW-1:0]     raddr_r, r_next_addr_s;
  logic [3:0]            rlen_r, rbeat_r;
  logic                  rincr_r, rerr_r, ar_err_s;
  logic [31:0]           rdata_r;
  logic                  ar_fire_s, r_fire_s, r_last_s;

  logic                  unused_s;
  assign unused_s = ^wid_i;

  assign aw_fire_s = awvalid_i && (w_state_r == W_IDLE);
  assign w_fire_s  = wvalid_i && (w_state_r == W_DATA);
  assign w_last_s  = (wbeat_r == wlen_r);
  assign mem_we_s  = w_fire_s && !werr_r;

  assign ar_fire_s     = arvalid_i && (r_state_r == R_IDLE);
  assign r_fire_s      = rready_i && (r_state_r == R_DATA);
  assign r_last_s      = (rbeat_r == rlen_r);
  assign ar_err_s      = burst_err(araddr_i, arlen_i, arsize_i, arburst_i);
  assign r_next_addr_s = rincr_r ? (raddr_r + MEM_AW'(1)) : raddr_r;

  assign awready_o = (w_state_r == W_IDLE);
  assign wready_o  = (w_state_r == W_DATA);
  assign bvalid_o  = (w_state_r == W_RESP);
  assign bid_o     = wid_r;
  assign bresp_o   = werr_r ? 2'b10 : 2'b00;

  assign arready_o = (r_state_r == R_IDLE);
  assign rvalid_o  = (r_state_r == R_DATA);
  assign rid_o     = rid_r;
  assign rdata_o   = rdata_r;
  assign rresp_o   = rerr_r ? 2'b10 : 2'b00;
  assign rlast_o   = (r_state_r == R_DATA) && r_last_s;

  // Write engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state_r <= W_IDLE;
    else     w_state_r <= w_state_nx_s;
  end

  // Write engine next state: the beat count ends the burst, not wlast
  always_comb begin
    w_state_nx_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_fire_s) w_state_nx_s = W_DATA; else w_state_nx_s = W_IDLE;
      W_DATA:  if (w_fire_s && w_last_s) w_state_nx_s = W_RESP; else w_state_nx_s = W_DATA;
      W_RESP:  if (bready_i) w_state_nx_s = W_IDLE; else w_state_nx_s = W_RESP;
      default: w_state_nx_s = W_IDLE;
    endcase
  end

  // Write burst context: the context is latched on AW and advanced on each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wid_r   <= '0;
      waddr_r <= '0;
      wlen_r  <= 4'd0;
      wbeat_r <= 4'd0;
      wincr_r <= 1'b0;
      werr_r  <= 1'b0;
    end else if (aw_fire_s) begin
      wid_r   <= awid_i;
      waddr_r <= awaddr_i[MEM_AW+1:2];
      wlen_r  <= awlen_i;
      wbeat_r <= 4'd0;
      wincr_r <= (awburst_i == 2'd1);
      werr_r  <= burst_err(awaddr_i, awlen_i, awsize_i, awburst_i);
    end else if (w_fire_s) begin
      wbeat_r <= wbeat_r + 4'd1;
      waddr_r <= wincr_r ? (waddr_r + MEM_AW'(1)) : waddr_r;
      // A misplaced wlast marks the response but does not end the burst early
      if (wlast_i != w_last_s) werr_r <= 1'b1;
    end
  end

  // Byte-lane write port. The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_r[waddr_r][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state_r <= R_IDLE;
    else     r_state_r <= r_state_nx_s;
  end

  // Read engine next state
  always_comb begin
    r_state_nx_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_fire_s) r_state_nx_s = R_DATA; else r_state_nx_s = R_IDLE;
      R_DATA:  if (r_fire_s && r_last_s) r_state_nx_s = R_IDLE; else r_state_nx_s = R_DATA;
      default: r_state_nx_s = R_IDLE;
    endcase
  end

  // Read burst context and registered read data. Data is fetched one beat
  // ahead at the edge, so a same-cycle write to that word is seen as old data.
  // The data also holds steady while R is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rid_r   <= '0;
      raddr_r <= '0;
      rlen_r  <= 4'd0;
      rbeat_r <= 4'd0;
      rincr_r <= 1'b0;
      rerr_r  <= 1'b0;
      rdata_r <= 32'd0;
    end else if (ar_fire_s) begin
      rid_r   <= arid_i;
      raddr_r <= araddr_i[MEM_AW+1:2];
      rlen_r  <= arlen_i;
      rbeat_r <= 4'd0;
      rincr_r <= (arburst_i == 2'd1);
      rerr_r  <= ar_err_s;
      rdata_r <= ar_err_s ? 32'd0 : mem_r[araddr_i[MEM_AW+1:2]];
    end else if (r_fire_s && !r_last_s) begin
      rbeat_r <= rbeat_r + 4'd1;
      raddr_r <= r_next_addr_s;
      rdata_r <= rerr_r ? 32'd0 : mem_r[r_next_addr_s];
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
  logic        clk, rst;
  logic [3:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_mem_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .MEM_AW(12)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          rmode  = 0;   // 0: R/B ready held high, 1: rready toggles, 2: random
  longint      cyc    = 0;
  logic [31:0] mm [4096];    // reference memory image
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [63:0] bq [$];
  logic [63:0] rq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s", name);
  endtask

  // The response rules written directly as arithmetic on byte addresses
  function automatic bit m_err(input logic [31:0] addr, input int len, input int size, input int burst);
    longint unsigned last_word;
    last_word = longint'(addr / 32'd4) + ((burst == 1) ? longint'(len) : 64'd0);
    return (size != 2) || (burst >= 2) || (addr % 32'd4 != 32'd0) || (last_word >= 64'd4096);
  endfunction

  // Ready drivers
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: begin rready = 1'b1; bready = 1'b1; end
        1: begin rready = ~rready; bready = 1'b1; end
        default: begin rready = 1'($urandom_range(0, 1)); bready = 1'($urandom_range(0, 1)); end
      endcase
    end
  end

  // Monitor and scoreboard. Signals are sampled on the falling edge, and a
  // valid&ready seen here completes at the next rising edge.
  logic        stall_prev = 1'b0;
  logic [38:0] stall_val;
  logic        bstall_prev = 1'b0;
  logic [5:0]  bstall_val;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev  = 1'b0;
        bstall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("r_stall_hold", {rvalid, rid, rresp, rlast, rdata}, {1'b1, stall_val});
        if (rvalid && rready) begin
          if (rq.size() == 0) fail_now("r_unexpected_beat");
          else chk("r_beat", 64'({rid, rresp, rlast, rdata}), rq.pop_front());
        end
        stall_prev = rvalid && !rready;
        stall_val  = {rid, rresp, rlast, rdata};
        if (bstall_prev) chk("b_stall_hold", {bvalid, bid, bresp}, {1'b1, bstall_val});
        if (bvalid && bready) begin
          if (bq.size() == 0) fail_now("b_unexpected");
          else chk("b_resp", 64'({bid, bresp}), bq.pop_front());
        end
        bstall_prev = bvalid && !bready;
        bstall_val  = {bid, bresp};
      end
    end
  end

  task automatic aw_issue(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    awid = id; awaddr = a; awlen = len[3:0]; awsize = sz; awburst = bu; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 200);
    if (!awready) fail_now("aw_timeout");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_issue(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] sz, input logic [1:0] bu);
    int n = 0;
    arid = id; araddr = a; arlen = len[3:0]; arsize = sz; arburst = bu; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 200);
    if (!arready) fail_now("ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Drive beats 0..last of wd/ws; beat len carries wlast
  task automatic w_beats(input int len, input int last);
    for (int i = 0; i <= last; i++) begin
      int n = 0;
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == len); wvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!wready && n < 200);
      if (!wready) fail_now("w_timeout");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write_txn(input logic [3:0] id, input logic [31:0] a, input int len,
                           input logic [2:0] sz, input logic [1:0] bu);
    bit err = m_err(a, len, sz, bu);
    bq.push_back(64'({id, (err ? 2'b10 : 2'b00)}));
    if (!err) begin
      for (int i = 0; i <= len; i++) begin
        int w = int'(a / 32'd4) + ((bu == 2'd1) ? i : 0);
        for (int b = 0; b < 4; b++) if (ws[i][b]) mm[w][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    aw_issue(id, a, len, sz, bu);
    w_beats(len, len);
  endtask

  task automatic read_txn(input logic [3:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] sz, input logic [1:0] bu);
    bit err = m_err(a, len, sz, bu);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] d;
      d = err ? 32'd0 : mm[int'(a / 32'd4) + ((bu == 2'd1) ? i : 0)];
      rq.push_back(64'({id, (err ? 2'b10 : 2'b00), (i == len), d}));
    end
    ar_issue(id, a, len, sz, bu);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      fail_now("idle_timeout");
      bq.delete(); rq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_data(input bit full);
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      ws[i] = full ? 4'hF : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    longint t0;
    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wlast = 1'b0;
    awid = 4'd0; awaddr = 32'd0; awlen = 4'd0; awsize = 3'd2; awburst = 2'd1;
    wid = 4'd0; wdata = 32'd0; wstrb = 4'd0;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'd2; arburst = 2'd1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b110000);
    chk("rst_ids_resp", {bid, rid, bresp, rresp}, 12'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Give words 0..1039 known contents
    for (int b = 0; b < 65; b++) begin
      rand_data(1'b1);
      write_txn(4'(b), 32'(b * 64), 15, 3'd2, 2'd1);
    end
    wait_idle();

    // 1) basic INCR write and readback
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    write_txn(4'd3, 32'h100, 3, 3'd2, 2'd1);
    wait_idle();
    read_txn(4'd5, 32'h100, 3, 3'd2, 2'd1);
    wait_idle();

    // 2) partial strobes
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    write_txn(4'd1, 32'h0, 0, 3'd2, 2'd1);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    write_txn(4'd2, 32'h0, 0, 3'd2, 2'd1);
    wait_idle();
    read_txn(4'd6, 32'h0, 0, 3'd2, 2'd1);
    wait_idle();

    // 3) 16-beat read with rready toggling
    rmode = 1;
    read_txn(4'd7, 32'h40, 15, 3'd2, 2'd1);
    wait_idle();
    rmode = 0;

    // 4) error bursts and array boundary
    rand_data(1'b1);
    write_txn(4'd8, 32'h100, 3, 3'd1, 2'd1);
    write_txn(4'd9, 32'h100, 3, 3'd2, 2'd2);
    write_txn(4'd10, 32'h4000, 0, 3'd2, 2'd1);
    write_txn(4'd11, 32'h3FF0, 7, 3'd2, 2'd1);
    write_txn(4'd12, 32'h3FFC, 0, 3'd2, 2'd1);
    wait_idle();
    read_txn(4'd1, 32'h100, 3, 3'd2, 2'd1);
    read_txn(4'd2, 32'h4000, 1, 3'd2, 2'd1);
    read_txn(4'd3, 32'h3FF8, 3, 3'd2, 2'd1);
    read_txn(4'd4, 32'h3FFC, 0, 3'd2, 2'd1);
    read_txn(4'd5, 32'h3FFC, 2, 3'd2, 2'd0);
    wait_idle();

    // 5) concurrent write and read on disjoint regions
    rand_data(1'b1);
    t0 = cyc;
    fork
      write_txn(4'd13, 32'h200, 15, 3'd2, 2'd1);
      read_txn(4'd14, 32'h1000, 15, 3'd2, 2'd1);
    join
    wait_idle();
    if (cyc - t0 > 24) fail_now("concurrency_latency");
    else chk("concurrency_latency", 64'(cyc - t0 <= 24), 64'd1);

    // 6) reset during beat 2 of an 8-beat write
    for (int i = 0; i < 8; i++) begin wd[i] = mm[192 + i] ^ 32'hFFFF0000; ws[i] = 4'hF; end
    aw_issue(4'd15, 32'h300, 7, 3'd2, 2'd1);
    w_beats(7, 1);
    wdata = wd[2]; wstrb = 4'hF; wvalid = 1'b1;
    #2 rst = 1'b1;
    wvalid = 1'b0;
    mm[192] = wd[0]; mm[193] = wd[1];
    repeat (2) @(negedge clk);
    chk("mid_rst_state", {bvalid, awready, wready}, 3'b010);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {bvalid, awready, wready, arready}, 4'b0101);
    @(posedge clk); #1;
    read_txn(4'd9, 32'h300, 7, 3'd2, 2'd1);
    wait_idle();

    // Randomized write/read traffic, including illegal bursts
    rmode = 2;
    for (int it = 0; it < 30; it++) begin
      int len = $urandom_range(0, 15);
      logic [1:0] bu = 2'($urandom_range(0, 1));
      logic [31:0] a = 32'($urandom_range(0, 1039 - len) * 4);
      logic [2:0] sz = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      if ($urandom_range(0, 9) == 0) a = a + 32'd2;
      rand_data(1'b0);
      write_txn(4'($urandom), a, len, sz, bu);
      wait_idle();
      len = $urandom_range(0, 15);
      a = 32'($urandom_range(0, 1039 - len) * 4);
      if ($urandom_range(0, 9) == 0) a = 32'h4000 - 32'd8;
      read_txn(4'($urandom), a, len, 3'd2, 2'($urandom_range(0, 1)));
      wait_idle();
    end
    rmode = 0;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
